potential_adder_scheduler: RTL and testbench

Time-multiplexes one `potential_adderNN`-style LIF floating-point adder across `N_NEURONS` neurons, one pass per timestep. On each `start` it:
- pulses the adder's set input once;
- walks every neuron index: fetches input weight and decayed potential, lets the adder settle, then writes back the final potential and the spike;
- returns a spike vector and a one-cycle `done`.

It sits between the timestep controller and the per-layer potential/weight memories in the 30-neuron accelerator.

---
 rtl/snn_sched_pkg.sv | 17 +
 rtl/potential_adder_scheduler.sv | 170 +++++++++++++++++
 tb/tb_potential_adder_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types and constants for the SNN potential-adder scheduling logic.
package snn_sched_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] DEFAULT_THRESHOLD = 32'h42200000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    READ   = 3'd2,
    FETCH  = 3'd3,
    SETTLE = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } sched_state_t;

endpackage

// File: rtl/potential_adder_scheduler.sv
// Time-multiplexes one external LIF FP32 adder across N_NEURONS neurons per timestep.
// Optional SPIKE_COUNT_EN adds a per-pass spike counter output.
module potential_adder_scheduler
  import snn_sched_pkg::*;
#(
  parameter int N_NEURONS     = 30,
  parameter int SETTLE_CYCLES = 2,
  parameter int AW            = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int SCW           = $clog2(N_NEURONS + 1)
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [FP_W-1:0]      weight_in,
  input  logic [FP_W-1:0]      potential_in,
  output logic                 set_adder,
  output logic                 clear_adder,
  output logic [FP_W-1:0]      adder_weight,
  output logic [FP_W-1:0]      adder_potential,
  input  logic [FP_W-1:0]      adder_result,
  input  logic                 adder_spike,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [FP_W-1:0]      wr_data,
  output logic [N_NEURONS-1:0] spike_vector
`ifdef SPIKE_COUNT_EN
  ,
  output logic [SCW-1:0]       spike_count
`endif
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  sched_state_t          r_state;
  sched_state_t          w_next_state;
  logic [AW-1:0]         r_index;
  logic [AW-1:0]         w_next_index;
  logic [SCNT_W-1:0]     r_settle_cnt;
  logic                  w_last;
  logic                  w_accept;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_en;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_set_adder;
  logic                  r_clear_adder;
  logic [FP_W-1:0]       r_adder_weight;
  logic [FP_W-1:0]       r_adder_potential;
  logic                  r_wr_en;
  logic [AW-1:0]         r_wr_addr;
  logic [FP_W-1:0]       r_wr_data;
  logic [N_NEURONS-1:0]  r_spike_vector;

  assign w_last   = (r_index == AW'(N_NEURONS - 1));
  assign w_accept = (r_state == IDLE) && start;

  // Next-state decode for the per-timestep pass.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (start) w_next_state = LOAD; else w_next_state = IDLE;
      LOAD:   w_next_state = READ;
      READ:   w_next_state = FETCH;
      FETCH:  w_next_state = SETTLE;
      SETTLE: if (r_settle_cnt <= SCNT_W'(1)) w_next_state = WRITE; else w_next_state = SETTLE;
      WRITE:  if (w_last) w_next_state = DONE; else w_next_state = READ;
      DONE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Neuron index: cleared on an accepted start, advanced after each write-back.
  always_comb begin
    w_next_index = r_index;
    if (w_accept) begin
      w_next_index = {AW{1'b0}};
    end else if ((r_state == WRITE) && !w_last) begin
      w_next_index = r_index + AW'(1);
    end else begin
      w_next_index = r_index;
    end
  end

  // State, counters and all outputs are registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state           <= IDLE;
      r_index           <= {AW{1'b0}};
      r_settle_cnt      <= {SCNT_W{1'b0}};
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_rd_en           <= 1'b0;
      r_rd_addr         <= {AW{1'b0}};
      r_set_adder       <= 1'b0;
      r_clear_adder     <= 1'b1;
      r_adder_weight    <= {FP_W{1'b0}};
      r_adder_potential <= {FP_W{1'b0}};
      r_wr_en           <= 1'b0;
      r_wr_addr         <= {AW{1'b0}};
      r_wr_data         <= {FP_W{1'b0}};
      r_spike_vector    <= {N_NEURONS{1'b0}};
    end else begin
      r_state       <= w_next_state;
      r_index       <= w_next_index;
      r_busy        <= (w_next_state != IDLE);
      r_done        <= (w_next_state == DONE);
      r_rd_en       <= (w_next_state == READ);
      r_set_adder   <= (w_next_state == LOAD);
      r_clear_adder <= (w_next_state == IDLE);
      if (w_next_state == READ) begin
        r_rd_addr <= w_next_index;
      end
      // Operands only move here so the adder sees stable inputs through SETTLE.
      if (r_state == FETCH) begin
        r_adder_weight    <= weight_in;
        r_adder_potential <= potential_in;
        r_settle_cnt      <= SCNT_W'(SETTLE_CYCLES);
      end else if (r_state == SETTLE) begin
        r_settle_cnt <= r_settle_cnt - SCNT_W'(1);
      end
      if (w_next_state == WRITE) begin
        r_wr_en                 <= 1'b1;
        r_wr_addr               <= r_index;
        r_wr_data               <= adder_result;
        r_spike_vector[r_index] <= adder_spike;
      end else begin
        r_wr_en <= 1'b0;
        if (w_accept) begin
          r_spike_vector <= {N_NEURONS{1'b0}};
        end
      end
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [SCW-1:0] r_spike_count;

  // Spikes seen in the current pass, held after DONE until the next start.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_spike_count <= {SCW{1'b0}};
    end else if (w_accept) begin
      r_spike_count <= {SCW{1'b0}};
    end else if ((w_next_state == WRITE) && adder_spike) begin
      r_spike_count <= r_spike_count + SCW'(1);
    end
  end

  assign spike_count = r_spike_count;
`endif

  assign busy            = r_busy;
  assign done            = r_done;
  assign rd_en           = r_rd_en;
  assign rd_addr         = r_rd_addr;
  assign set_adder       = r_set_adder;
  assign clear_adder     = r_clear_adder;
  assign adder_weight    = r_adder_weight;
  assign adder_potential = r_adder_potential;
  assign wr_en           = r_wr_en;
  assign wr_addr         = r_wr_addr;
  assign wr_data         = r_wr_data;
  assign spike_vector    = r_spike_vector;

endmodule

// File: tb/tb_potential_adder_scheduler.sv
// Directed bench: a 30-neuron and a 1-neuron scheduler against a memory model and adder stub.
module tb_potential_adder_scheduler;
  import snn_sched_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_1 = 1'b0;
  logic        odd_mode = 1'b0;
  logic        load_pot = 1'b0;

  logic        busy, done, rd_en, set_adder, clear_adder, adder_spike, wr_en;
  logic [4:0]  rd_addr, wr_addr;
  logic [31:0] weight_in, potential_in, adder_weight, adder_potential, adder_result, wr_data;
  logic [29:0] spike_vector;
`ifdef SPIKE_COUNT_EN
  logic [4:0]  spike_count;
  logic [0:0]  spike_count_1;
`endif

  logic        busy_1, done_1, rd_en_1, set_adder_1, clear_adder_1, adder_spike_1, wr_en_1;
  logic [0:0]  rd_addr_1, wr_addr_1, spike_vector_1;
  logic [31:0] weight_in_1, potential_in_1, adder_weight_1, adder_potential_1, adder_result_1, wr_data_1;

  logic [31:0] p_mem [30];
  logic [4:0]  wlog_addr [256];
  logic [31:0] wlog_data [256];
  int          wr_cnt = 0, done_cnt = 0, set_cnt = 0, w1_cnt = 0;
  logic [31:0] w1_data = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  potential_adder_scheduler #(.N_NEURONS(30), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .weight_in(weight_in), .potential_in(potential_in),
    .set_adder(set_adder), .clear_adder(clear_adder), .adder_weight(adder_weight),
    .adder_potential(adder_potential), .adder_result(adder_result), .adder_spike(adder_spike),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .spike_vector(spike_vector)
`ifdef SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  potential_adder_scheduler #(.N_NEURONS(1), .SETTLE_CYCLES(2)) dut_1 (
    .CLK(CLK), .reset(reset), .start(start_1), .busy(busy_1), .done(done_1),
    .rd_en(rd_en_1), .rd_addr(rd_addr_1), .weight_in(weight_in_1), .potential_in(potential_in_1),
    .set_adder(set_adder_1), .clear_adder(clear_adder_1), .adder_weight(adder_weight_1),
    .adder_potential(adder_potential_1), .adder_result(adder_result_1), .adder_spike(adder_spike_1),
    .wr_en(wr_en_1), .wr_addr(wr_addr_1), .wr_data(wr_data_1), .spike_vector(spike_vector_1)
`ifdef SPIKE_COUNT_EN
    , .spike_count(spike_count_1)
`endif
  );

  // Adder stub with threshold 40.0: 20+30 fires and leaves 10.0, 10+30 stays at 40.0.
  function automatic logic [32:0] adder_model(input logic [31:0] w, input logic [31:0] p);
    if (w == 32'h41A00000 && p == 32'h41F00000) return {1'b1, 32'h41200000};
    else if (w == 32'h41200000 && p == 32'h41F00000) return {1'b0, 32'h42200000};
    else return {1'b0, w ^ p};
  endfunction

  assign {adder_spike, adder_result}     = adder_model(adder_weight, adder_potential);
  assign {adder_spike_1, adder_result_1} = adder_model(adder_weight_1, adder_potential_1);

  // Memories with one-cycle read latency; odd neurons get 20.0 in odd_mode.
  always @(posedge CLK) begin
    if (rd_en) begin
      weight_in    <= (odd_mode && rd_addr[0]) ? 32'h41A00000 : 32'h41200000;
      potential_in <= p_mem[rd_addr];
    end
    if (load_pot) begin
      for (int i = 0; i < 30; i++) p_mem[i] <= 32'h41F00000;
    end else if (wr_en) begin
      p_mem[wr_addr] <= wr_data;
    end
    if (rd_en_1) begin
      weight_in_1    <= 32'h41A00000;
      potential_in_1 <= 32'h41F00000;
    end
  end

  // Event log sampled away from the active edge.
  always @(negedge CLK) begin
    if (wr_en) begin
      if (wr_cnt < 256) begin
        wlog_addr[wr_cnt] = wr_addr;
        wlog_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (set_adder) set_cnt = set_cnt + 1;
    if (wr_en_1) begin
      w1_cnt  = w1_cnt + 1;
      w1_data = wr_data_1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reload_pot();
    @(negedge CLK) load_pot = 1'b1;
    @(negedge CLK) load_pot = 1'b0;
  endtask

  // Pulse start, optionally re-pulse at cycle repulse_at and in the DONE cycle; cyc = start-to-done.
  task automatic run_pass(input int repulse_at, input bit pulse_on_done, output int cyc);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      start = (cyc == repulse_at);
      @(negedge CLK);
      cyc++;
    end
    start = pulse_on_done;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_set"}, set_adder, 1'b0);
    check({tag, "_clear"}, clear_adder, 1'b1);
    check({tag, "_rd_addr"}, rd_addr, 5'd0);
    check({tag, "_wr_data"}, wr_data, 32'h0);
    check({tag, "_operand"}, adder_weight, 32'h0);
    check({tag, "_spikes"}, spike_vector, 30'h0);
  endtask

  initial begin
    int cyc;
    int wb, db, sb;

    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (20) @(negedge CLK);
    check("idle_writes", wr_cnt, 0);
    check_reset_outputs("idle");

    // Single neuron: 20 + 30 crosses 40, potential reset to 10.
    @(negedge CLK) start_1 = 1'b1;
    @(negedge CLK) start_1 = 1'b0;
    cyc = 1;
    while (!done_1 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check("n1_done_cycle", cyc, 7);
    check("n1_writes", w1_cnt, 1);
    check("n1_wr_data", w1_data, 32'h41200000);
    check("n1_spikes", spike_vector_1, 1'b1);
    @(negedge CLK);
    check("n1_busy_after", busy_1, 1'b0);

    // All neurons at exactly threshold: no spikes.
    reload_pot();
    wb = wr_cnt; db = done_cnt; sb = set_cnt;
    run_pass(-1, 1'b0, cyc);
    check("flat_done_cycle", cyc, 152);
    check("flat_writes", wr_cnt - wb, 30);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("flat_addr%0d", i), wlog_addr[wb + i], i);
      check($sformatf("flat_data%0d", i), wlog_data[wb + i], 32'h42200000);
    end
    check("flat_spikes", spike_vector, 30'h0);
    check("flat_set_pulses", set_cnt - sb, 1);
    check("flat_mem29", p_mem[29], 32'h42200000);

    // Odd neurons fire; extra starts mid-pass and in DONE are dropped.
    odd_mode = 1'b1;
    reload_pot();
    wb = wr_cnt; db = done_cnt;
    run_pass(60, 1'b1, cyc);
    repeat (10) @(negedge CLK);
    check("odd_done_cycle", cyc, 152);
    check("odd_writes", wr_cnt - wb, 30);
    check("odd_done_pulses", done_cnt - db, 1);
    check("odd_busy_after", busy, 1'b0);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("odd_data%0d", i), wlog_data[wb + i],
            (i % 2 == 1) ? 32'h41200000 : 32'h42200000);
    end
    check("odd_spikes_held", spike_vector, 30'h2AAAAAAA);
`ifdef SPIKE_COUNT_EN
    check("odd_spike_count", spike_count, 5'd15);
`endif

    // Reset during neuron 10 SETTLE.
    reload_pot();
    wb = wr_cnt;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    cyc = 1;
    while (cyc < 54) begin
      @(negedge CLK);
      cyc++;
    end
    reset = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    check("midrst_writes", wr_cnt - wb, 10);
    check("midrst_last_addr", wlog_addr[wb + 9], 5'd9);
    check("midrst_mem9", p_mem[9], 32'h41200000);
    check("midrst_mem10", p_mem[10], 32'h41F00000);
    check("midrst_mem29", p_mem[29], 32'h41F00000);
    reload_pot();
    wb = wr_cnt;
    run_pass(-1, 1'b0, cyc);
    check("fresh_done_cycle", cyc, 152);
    check("fresh_writes", wr_cnt - wb, 30);
    check("fresh_spikes", spike_vector, 30'h2AAAAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
